imem_boot_loader: RTL and testbench

Sequential loader that fills the instruction memory from a byte-stream source (UART/debug link) before the core runs. Assembles incoming bytes little-endian into 32-bit words and issues one word-aligned write per word at sequential addresses starting at 0. Holds the core stalled (cpu_hold) for the whole load and signals completion, so fetch only sees a fully loaded program.

---
 rtl/imem_boot_loader_if.sv | 23 ++
 rtl/imem_boot_loader.sv | 81 ++++++++
 tb/tb_imem_boot_loader.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/imem_boot_loader_if.sv
// imem_boot_loader_if: byte-stream in, instruction-memory write and core-hold signals out.
interface imem_boot_loader_if #(parameter int IDX_W = 8);
  logic             start;
  logic [IDX_W:0]   word_count;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             byte_ready;
  logic             we;
  logic [31:0]      waddr;
  logic [31:0]      wdata;
  logic             cpu_hold;
  logic             busy;
  logic             done;
  logic             err;
  modport master (
    output start, word_count, byte_valid, byte_data,
    input  byte_ready, we, waddr, wdata, cpu_hold, busy, done, err
  );
  modport slave (
    input  start, word_count, byte_valid, byte_data,
    output byte_ready, we, waddr, wdata, cpu_hold, busy, done, err
  );
endinterface

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: assembles a little-endian byte stream into words and writes them to
// instruction memory from address 0, holding the core until the whole program is loaded.
module imem_boot_loader #(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  imem_boot_loader_if.slave ldr
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RECV  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] FIN   = 2'd3;
  localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);
  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [IDX_W:0]   count_q, count_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             err_q, err_d;
  logic             xfer, last;
  assign xfer = ldr.byte_valid & ldr.byte_ready;
  assign last = {1'b0, idx_q} == count_q - 1'b1;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (ldr.start) begin
        if (ldr.word_count == '0) state_d = FIN;
        else if (ldr.word_count > DEPTH_C) err_d = 1'b1;
        else begin
          count_d = ldr.word_count;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = RECV;
        end
      end
      RECV: if (xfer) begin
        wdata_d[{cnt_q, 3'b000} +: 8] = ldr.byte_data;
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_q == 2'd3 ? WRITE : RECV;
      end
      WRITE: begin
        state_d = last ? FIN : RECV;
        idx_d   = last ? idx_q : idx_q + 1'b1;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      count_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end
  assign ldr.byte_ready = state_q == RECV;
  assign ldr.we         = state_q == WRITE;
  assign ldr.done       = state_q == FIN;
  assign ldr.busy       = state_q != IDLE;
  assign ldr.cpu_hold   = state_q != IDLE;
  assign ldr.err        = err_q;
  assign ldr.waddr      = {{(30-IDX_W){1'b0}}, idx_q, 2'b00};
  assign ldr.wdata      = wdata_q;
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: vector table for cycle-exact behaviour plus directed multi-cycle loads.
module tb_imem_boot_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  imem_boot_loader_if #(.IDX_W(8)) bus();
  imem_boot_loader #(.DEPTH(256), .IDX_W(8)) dut (.clk(clk), .rst_n(rst_n), .ldr(bus));
  typedef struct {
    logic       start;
    logic [8:0] wc;
    logic       bv;
    logic [7:0] bd;
    logic [5:0] flags;
    logic [31:0] waddr;
    logic [31:0] wdata;
  } vec_t;
  vec_t vecs[$];
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [7:0]  src_q[$];
  int cmp_cnt = 0;
  int fail_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int bad_cnt = 0;
  always @(negedge clk) begin
    if (bus.we) begin
      wa_q.push_back(bus.waddr);
      wd_q.push_back(bus.wdata);
    end
    if (bus.done) done_cnt++;
    if (bus.err) err_cnt++;
    if ((bus.done && bus.err) || ((bus.done || bus.err) && bus.we)) bad_cnt++;
  end
  function automatic logic [5:0] flags();
    return {bus.byte_ready, bus.we, bus.cpu_hold, bus.busy, bus.done, bus.err};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic add(input logic s, input logic [8:0] wc, input logic bv, input logic [7:0] bd,
                     input logic [5:0] f, input logic [31:0] wa, input logic [31:0] wd);
    vec_t v;
    v.start = s; v.wc = wc; v.bv = bv; v.bd = bd; v.flags = f; v.waddr = wa; v.wdata = wd;
    vecs.push_back(v);
  endtask
  task automatic do_start(input logic [8:0] wc);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.word_count = wc;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.word_count = 9'd3;
  endtask
  task automatic stream(input bit gap, input int budget);
    int n = 0;
    while (src_q.size() > 0 && n < budget) begin
      bus.byte_valid = !gap || n[0];
      bus.byte_data = bus.byte_valid ? src_q[0] : 8'h00;
      if (bus.byte_valid && bus.byte_ready) void'(src_q.pop_front());
      @(posedge clk); #1;
      n++;
    end
    bus.byte_valid = 1'b0;
    chk("stream_left", src_q.size(), 0);
    src_q.delete();
  endtask
  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_pulse", done_cnt - d0, 1);
  endtask
  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) src_q.push_back(w[8*b +: 8]);
  endtask
  function automatic logic [31:0] pat(input int k);
    logic [7:0] kb = 8'(k);
    return {kb, 8'hC3, ~kb, kb + 8'd1};
  endfunction
  initial begin
    int e0;
    bus.start = 1'b0;
    bus.word_count = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_flags", 32'(flags()), 0);
    chk("reset_waddr", bus.waddr, 0);
    chk("reset_wdata", bus.wdata, 0);
    #4 rst_n = 1'b1;
    add(1, 9'd1,   0, 8'h00, 6'b000000, 0, 0);
    add(0, 9'd0,   1, 8'h13, 6'b101100, 0, 0);
    add(0, 9'd0,   1, 8'h00, 6'b101100, 0, 0);
    add(0, 9'd0,   1, 8'h00, 6'b101100, 0, 0);
    add(0, 9'd0,   1, 8'h00, 6'b101100, 0, 0);
    add(0, 9'd0,   1, 8'hAA, 6'b011100, 32'h0, 32'h0000_0013);
    add(0, 9'd0,   1, 8'hAA, 6'b001110, 0, 0);
    add(1, 9'd257, 0, 8'h00, 6'b000000, 0, 0);
    add(0, 9'd0,   0, 8'h00, 6'b000001, 0, 0);
    add(1, 9'd0,   0, 8'h00, 6'b000000, 0, 0);
    add(0, 9'd0,   0, 8'h00, 6'b001110, 0, 0);
    add(0, 9'd0,   0, 8'h00, 6'b000000, 0, 0);
    foreach (vecs[i]) begin
      @(posedge clk); #1;
      bus.start = vecs[i].start;
      bus.word_count = vecs[i].wc;
      bus.byte_valid = vecs[i].bv;
      bus.byte_data = vecs[i].bd;
      chk($sformatf("vec%0d_flags", i), 32'(flags()), 32'(vecs[i].flags));
      if (vecs[i].flags[4]) begin
        chk($sformatf("vec%0d_waddr", i), bus.waddr, vecs[i].waddr);
        chk($sformatf("vec%0d_wdata", i), bus.wdata, vecs[i].wdata);
      end
    end
    bus.start = 1'b0;
    bus.byte_valid = 1'b0;
    chk("table_writes", wa_q.size(), 1);
    wa_q.delete(); wd_q.delete();
    // Gapped stream: valid drops every other cycle
    do_start(9'd2);
    push_word(32'hDEAD_BEEF);
    push_word(32'h1234_5678);
    stream(1, 100);
    wait_done(20);
    chk("hold_after_done", 32'(bus.cpu_hold), 0);
    chk("gap_writes", wa_q.size(), 2);
    if (wa_q.size() == 2) begin
      chk("gap_addr0", wa_q[0], 32'h0);
      chk("gap_data0", wd_q[0], 32'hDEAD_BEEF);
      chk("gap_addr1", wa_q[1], 32'h4);
      chk("gap_data1", wd_q[1], 32'h1234_5678);
    end
    wa_q.delete(); wd_q.delete();
    // Full-depth load
    do_start(9'd256);
    for (int k = 0; k < 256; k++) push_word(pat(k));
    stream(0, 2000);
    wait_done(10);
    chk("full_writes", wa_q.size(), 256);
    if (wa_q.size() == 256) begin
      for (int k = 0; k < 256; k++) begin
        chk($sformatf("full_addr%0d", k), wa_q[k], 32'(4 * k));
        chk($sformatf("full_data%0d", k), wd_q[k], pat(k));
      end
      chk("full_last_addr", wa_q[255], 32'h3FC);
    end
    wa_q.delete(); wd_q.delete();
    // Reset after two words and half of a third
    do_start(9'd4);
    push_word(32'h0A0B_0C0D);
    push_word(32'h1111_2222);
    src_q.push_back(8'h77);
    src_q.push_back(8'h66);
    stream(0, 50);
    rst_n = 1'b0;
    #1;
    chk("midrst_flags", 32'(flags()), 0);
    chk("midrst_waddr", bus.waddr, 0);
    chk("midrst_wdata", bus.wdata, 0);
    #2 rst_n = 1'b1;
    wa_q.delete(); wd_q.delete();
    bus.byte_valid = 1'b1;
    bus.byte_data = 8'h55;
    repeat (6) @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
    chk("midrst_no_write", wa_q.size(), 0);
    chk("midrst_idle", 32'(bus.busy), 0);
    do_start(9'd1);
    push_word(32'h0403_0201);
    stream(0, 20);
    wait_done(10);
    chk("reload_writes", wa_q.size(), 1);
    if (wa_q.size() == 1) begin
      chk("reload_addr", wa_q[0], 32'h0);
      chk("reload_data", wd_q[0], 32'h0403_0201);
    end
    wa_q.delete(); wd_q.delete();
    // Start pulse while a load is running
    e0 = err_cnt;
    do_start(9'd2);
    src_q.push_back(8'h21);
    src_q.push_back(8'h43);
    stream(0, 10);
    bus.start = 1'b1;
    bus.word_count = 9'd300;
    @(posedge clk); #1;
    bus.start = 1'b0;
    src_q.push_back(8'h65);
    src_q.push_back(8'h87);
    push_word(32'hCAFE_F00D);
    stream(0, 30);
    wait_done(10);
    chk("busy_start_err", err_cnt - e0, 0);
    chk("busy_start_writes", wa_q.size(), 2);
    if (wa_q.size() == 2) begin
      chk("busy_data0", wd_q[0], 32'h8765_4321);
      chk("busy_addr1", wa_q[1], 32'h4);
      chk("busy_data1", wd_q[1], 32'hCAFE_F00D);
    end
    chk("exclusive_pulses", bad_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end
endmodule
